// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, exception-vector positions, ExcCodes and write masks
package cp0_pkg;
  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam int EXC_INT     = 0;
  localparam int EXC_ADEL_IF = 1;
  localparam int EXC_RI      = 2;
  localparam int EXC_OV      = 3;
  localparam int EXC_SYS     = 4;
  localparam int EXC_BP      = 5;
  localparam int EXC_ADEL_D  = 6;
  localparam int EXC_ADES    = 7;
  localparam int EXC_TLBL    = 8;
  localparam int EXC_TLBS    = 12;
  localparam int EXC_MOD     = 14;
  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_MOD  = 5'd1;
  localparam logic [4:0] CODE_TLBL = 5'd2;
  localparam logic [4:0] CODE_TLBS = 5'd3;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [31:0] MASK_ENTRYLO = 32'h03ff_ffff;
  localparam logic [31:0] MASK_ENTRYHI = 32'hffff_e0ff;
  localparam logic [31:0] MASK_STATUS  = 32'h0000_ff03;
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
  function automatic logic [4:0] exc_code(input logic [3:0] b);
    return b == 4'(EXC_INT) ? CODE_INT :
           b == 4'(EXC_ADEL_IF) || b == 4'(EXC_ADEL_D) ? CODE_ADEL :
           b == 4'(EXC_RI) ? CODE_RI :
           b == 4'(EXC_OV) ? CODE_OV :
           b == 4'(EXC_SYS) ? CODE_SYS :
           b == 4'(EXC_BP) ? CODE_BP :
           b == 4'(EXC_ADES) ? CODE_ADES :
           b < 4'(EXC_TLBS) ? CODE_TLBL :
           b < 4'(EXC_MOD) ? CODE_TLBS : CODE_MOD;
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: half-rate Count, Compare and the sticky timer-interrupt flag
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  logic tick;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tick    <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      tick    <= ~tick;
      count   <= count_we ? wdata : count + 32'(tick);
      compare <= compare_we ? wdata : compare;
      ti      <= compare_we ? 1'b0 : (count == compare) | ti;
    end
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 registers driven by write-back commits; serves mfc0, EPC, irq and TLB staging
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    ext_int,
  input  logic          ws_mtc0_op,
  input  logic          ws_mfc0_op,
  input  logic [4:0]    ws_rd,
  input  logic [31:0]   ws_rt_value,
  output logic [31:0]   ws_mfc0_data,
  input  logic [14:0]   ws_exception_cmt,
  input  logic          ws_eret_cmt,
  input  logic          ws_inst_in_slot,
  input  logic [31:0]   ws_pc,
  input  logic [31:0]   ws_badvaddr,
  output logic [31:0]   cp0_epc,
  output logic          cp0_int_req,
  output logic          cp0_status_exl,
  input  logic          tlbp_op,
  input  logic          tlbp_index_p,
  input  logic [5:0]    tlbp_index_index,
  input  logic          tlbr_op,
  input  logic          tlbwi_op,
  input  logic [31:0]   tlb_r_entryhi,
  input  logic [31:0]   tlb_r_entrylo0,
  input  logic [31:0]   tlb_r_entrylo1,
  output logic [IW-1:0] tlb_index,
  output logic [31:0]   tlb_entryhi,
  output logic [31:0]   tlb_entrylo0,
  output logic [31:0]   tlb_entrylo1,
  output logic          tlb_we
);
  logic          index_p, bd;
  logic [IW-1:0] index_idx;
  logic [31:0]   entrylo0, entrylo1, entryhi, badvaddr, status, epc, count, compare;
  logic [31:0]   index_rd, cause_rd;
  logic [5:0]    ip_hw;
  logic [1:0]    ip_sw;
  logic [4:0]    exccode;
  logic [3:0]    exc_bit;
  logic          exc, wr, ti, unused;
  assign exc = |ws_exception_cmt;
  assign wr  = ws_mtc0_op & ~exc & ~ws_eret_cmt;
  assign unused = ws_mfc0_op ^ ^tlbp_index_index[5:IW];
  always_comb begin
    exc_bit = '0;
    for (int i = 14; i >= 0; i--)
      if (ws_exception_cmt[i]) exc_bit = 4'(i);
  end
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr && ws_rd == CP0_COUNT),
    .compare_we (wr && ws_rd == CP0_COMPARE),
    .wdata      (ws_rt_value),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      index_p   <= 1'b0;
      index_idx <= '0;
      entrylo0  <= '0;
      entrylo1  <= '0;
      entryhi   <= '0;
      badvaddr  <= '0;
      status    <= STATUS_BEV;
      epc       <= '0;
      bd        <= 1'b0;
      ip_hw     <= '0;
      ip_sw     <= '0;
      exccode   <= '0;
    end else begin
      ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
      if (exc) begin
        if (!status[1]) begin
          epc <= ws_inst_in_slot ? ws_pc - 32'd4 : ws_pc;
          bd  <= ws_inst_in_slot;
        end
        status[1] <= 1'b1;
        exccode   <= exc_code(exc_bit);
        if (exc_bit == 4'(EXC_ADEL_IF) || exc_bit >= 4'(EXC_ADEL_D)) badvaddr <= ws_badvaddr;
        if (exc_bit >= 4'(EXC_TLBL)) entryhi[31:13] <= ws_badvaddr[31:13];
      end else if (ws_eret_cmt) status[1] <= 1'b0;
      else if (wr)
        case (ws_rd)
          CP0_INDEX:    index_idx <= ws_rt_value[IW-1:0];
          CP0_ENTRYLO0: entrylo0  <= ws_rt_value & MASK_ENTRYLO;
          CP0_ENTRYLO1: entrylo1  <= ws_rt_value & MASK_ENTRYLO;
          CP0_ENTRYHI:  entryhi   <= ws_rt_value & MASK_ENTRYHI;
          CP0_STATUS:   status    <= (ws_rt_value & MASK_STATUS) | STATUS_BEV;
          CP0_CAUSE:    ip_sw     <= ws_rt_value[9:8];
          CP0_EPC:      epc       <= ws_rt_value;
          default: ;
        endcase
      // TLB probes/reads override a same-cycle mtc0 but never an exception
      if (!exc && tlbp_op) begin
        index_p   <= tlbp_index_p;
        index_idx <= tlbp_index_index[IW-1:0];
      end
      if (!exc && tlbr_op) begin
        entryhi  <= tlb_r_entryhi & MASK_ENTRYHI;
        entrylo0 <= tlb_r_entrylo0 & MASK_ENTRYLO;
        entrylo1 <= tlb_r_entrylo1 & MASK_ENTRYLO;
      end
    end
  assign index_rd = {index_p, {(31 - IW){1'b0}}, index_idx};
  assign cause_rd = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};
  assign ws_mfc0_data = ws_rd == CP0_INDEX    ? index_rd :
                        ws_rd == CP0_ENTRYLO0 ? entrylo0 :
                        ws_rd == CP0_ENTRYLO1 ? entrylo1 :
                        ws_rd == CP0_BADVADDR ? badvaddr :
                        ws_rd == CP0_COUNT    ? count :
                        ws_rd == CP0_ENTRYHI  ? entryhi :
                        ws_rd == CP0_COMPARE  ? compare :
                        ws_rd == CP0_STATUS   ? status :
                        ws_rd == CP0_CAUSE    ? cause_rd :
                        ws_rd == CP0_EPC      ? epc : '0;
  assign cp0_epc        = epc;
  assign cp0_status_exl = status[1];
  assign cp0_int_req    = status[0] & ~status[1] & |({ip_hw, ip_sw} & status[15:8]);
  assign tlb_index      = index_idx;
  assign tlb_entryhi    = entryhi;
  assign tlb_entrylo0   = entrylo0;
  assign tlb_entrylo1   = entrylo1;
  assign tlb_we         = tlbwi_op;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed vectors with hand-computed expectations for cp0_regfile
module tb_cp0_regfile;
  logic        clk = 1'b0, reset = 1'b1;
  logic [5:0]  ext_int = '0;
  logic        ws_mtc0_op = 0, ws_mfc0_op = 0, ws_eret_cmt = 0, ws_inst_in_slot = 0;
  logic [4:0]  ws_rd = '0;
  logic [31:0] ws_rt_value = '0, ws_pc = '0, ws_badvaddr = '0, ws_mfc0_data, cp0_epc;
  logic [14:0] ws_exception_cmt = '0;
  logic        cp0_int_req, cp0_status_exl;
  logic        tlbp_op = 0, tlbp_index_p = 0, tlbr_op = 0, tlbwi_op = 0, tlb_we;
  logic [5:0]  tlbp_index_index = '0;
  logic [31:0] tlb_r_entryhi = '0, tlb_r_entrylo0 = '0, tlb_r_entrylo1 = '0;
  logic [3:0]  tlb_index;
  logic [31:0] tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
  logic [31:0] d, c0, c1;
  int errors = 0, checks = 0;
  cp0_regfile dut (
    .clk(clk), .reset(reset), .ext_int(ext_int),
    .ws_mtc0_op(ws_mtc0_op), .ws_mfc0_op(ws_mfc0_op), .ws_rd(ws_rd),
    .ws_rt_value(ws_rt_value), .ws_mfc0_data(ws_mfc0_data),
    .ws_exception_cmt(ws_exception_cmt), .ws_eret_cmt(ws_eret_cmt),
    .ws_inst_in_slot(ws_inst_in_slot), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr),
    .cp0_epc(cp0_epc), .cp0_int_req(cp0_int_req), .cp0_status_exl(cp0_status_exl),
    .tlbp_op(tlbp_op), .tlbp_index_p(tlbp_index_p), .tlbp_index_index(tlbp_index_index),
    .tlbr_op(tlbr_op), .tlbwi_op(tlbwi_op),
    .tlb_r_entryhi(tlb_r_entryhi), .tlb_r_entrylo0(tlb_r_entrylo0), .tlb_r_entrylo1(tlb_r_entrylo1),
    .tlb_index(tlb_index), .tlb_entryhi(tlb_entryhi), .tlb_entrylo0(tlb_entrylo0),
    .tlb_entrylo1(tlb_entrylo1), .tlb_we(tlb_we)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    ws_rd = a;
    #1 v = ws_mfc0_data;
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    ws_mtc0_op = 1; ws_rd = a; ws_rt_value = v;
    step();
    ws_mtc0_op = 0;
  endtask
  task automatic commit_exc(input logic [14:0] e, input logic [31:0] pc, input logic slot);
    ws_exception_cmt = e; ws_pc = pc; ws_inst_in_slot = slot;
    step();
    ws_exception_cmt = '0; ws_inst_in_slot = 0;
  endtask
  task automatic eret();
    ws_eret_cmt = 1;
    step();
    ws_eret_cmt = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rd(12, d); check("rst_status", d, 32'h0040_0000);
    rd(13, d); check("rst_cause", d, 32'h0);
    rd(9, d);  check("rst_count", d, 32'h0);
    check("rst_epc", cp0_epc, 32'h0);
    check("rst_irq", {31'b0, cp0_int_req}, 32'h0);
    @(negedge clk); reset = 0;
    repeat (10) step();
    rd(9, d); check("count_10cyc", d, 32'd5);
    mtc0(11, 32'hffff_ffff);
    repeat (2) step();
    rd(13, d); check("cause_quiet", d, 32'h0);
    commit_exc(15'h0008, 32'hbfc0_1004, 1'b1);
    rd(14, d); check("ov_epc", d, 32'hbfc0_1000);
    rd(13, d); check("ov_cause", d, 32'h8000_0030);
    check("ov_exl", {31'b0, cp0_status_exl}, 32'h1);
    commit_exc(15'h0010, 32'h8000_0100, 1'b0);
    check("exl_epc_hold", cp0_epc, 32'hbfc0_1000);
    rd(13, d); check("sys_cause", d, 32'h8000_0020);
    eret();
    check("eret_exl", {31'b0, cp0_status_exl}, 32'h0);
    mtc0(12, 32'h0000_8001);
    mtc0(11, 32'd20);
    mtc0(9, 32'd10);
    for (int i = 0; i < 100 && !cp0_int_req; i++) step();
    check("ti_irq", {31'b0, cp0_int_req}, 32'h1);
    rd(13, d); check("ti_set", {31'b0, d[30]}, 32'h1);
    check("ti_ip7", {31'b0, d[15]}, 32'h1);
    mtc0(11, 32'd1000);
    rd(13, d); check("ti_clear", {31'b0, d[30]}, 32'h0);
    step();
    check("irq_clear", {31'b0, cp0_int_req}, 32'h0);
    rd(9, c0);
    ws_mtc0_op = 1; ws_rt_value = 32'hdead_0000;
    commit_exc(15'h0001, 32'h8000_0200, 1'b0);
    ws_mtc0_op = 0;
    rd(9, c1); check("cnt_drop", {31'b0, (c1 - c0) <= 32'd1}, 32'h1);
    rd(13, d); check("int_code", {27'b0, d[6:2]}, 32'd0);
    eret();
    tlbp_op = 1; tlbp_index_p = 1; ws_badvaddr = 32'h1234_5678;
    commit_exc(15'h0100, 32'h8000_0300, 1'b0);
    tlbp_op = 0;
    rd(8, d);  check("tlbl_badv", d, 32'h1234_5678);
    rd(10, d); check("tlbl_vpn2", {13'b0, d[31:13]}, 32'h0009_1a2);
    rd(13, d); check("tlbl_code", {27'b0, d[6:2]}, 32'd2);
    rd(0, d);  check("tlbl_index_hold", d, 32'h0);
    eret();
    tlbp_op = 1; tlbp_index_p = 1; tlbp_index_index = 6'd3;
    step();
    rd(0, d); check("tlbp_miss", d, 32'h8000_0003);
    tlbp_index_p = 0; tlbp_index_index = 6'd5;
    step();
    tlbp_op = 0;
    rd(0, d); check("tlbp_hit", d, 32'h0000_0005);
    tlbr_op = 1; tlb_r_entryhi = 32'h1357_e055;
    tlb_r_entrylo0 = 32'hffff_ffff; tlb_r_entrylo1 = 32'h0123_4567;
    step();
    tlbr_op = 0;
    check("tlbr_hi", tlb_entryhi, 32'h1357_e055);
    check("tlbr_lo0", tlb_entrylo0, 32'h03ff_ffff);
    check("tlbr_lo1", tlb_entrylo1, 32'h0123_4567);
    tlbwi_op = 1;
    #1 check("tlbwi_we", {31'b0, tlb_we}, 32'h1);
    check("tlbwi_idx", {28'b0, tlb_index}, 32'd5);
    step();
    tlbwi_op = 0;
    #1 check("tlbwi_drop", {31'b0, tlb_we}, 32'h0);
    ws_mtc0_op = 1; ws_rt_value = 32'hffff_ffff;
    rd(12, d); check("mfc0_old", d, 32'h0040_8001);
    step();
    ws_mtc0_op = 0;
    rd(12, d); check("status_mask", d, 32'h0040_ff03);
    ext_int = 6'b000100;
    rd(13, d); check("ip4_before", {31'b0, d[12]}, 32'h0);
    step();
    rd(13, d); check("ip4_after", {31'b0, d[12]}, 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
